// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial adder controller: sequencing
// states and the default operand width.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrlState_t;

endpackage

// File: rtl/full_adder_cell.sv
// Full adder built from two half adders and an OR gate. The serial
// controller reuses this single cell for every bit position.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic w_partSum;
    logic w_partCarry;
    logic w_finalCarry;

    halfAdder u_haOperands (
        .a (a),
        .b (b),
        .s (w_partSum),
        .c (w_partCarry)
    );

    halfAdder u_haCarryIn (
        .a (w_partSum),
        .b (cin),
        .s (s),
        .c (w_finalCarry)
    );

    or_gate u_carryMerge (
        .a (w_partCarry),
        .b (w_finalCarry),
        .y (co)
    );

endmodule

// File: rtl/halfAdder.sv
// Half adder: sum and carry of two single-bit inputs.
module halfAdder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Sum is the parity of the inputs, carry is their conjunction.
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

endmodule

// File: rtl/or_gate.sv
// Two-input OR, used to merge the half-adder carries.
module or_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    // Either half adder producing a carry means the full adder carries.
    always_comb begin
        y = a | b;
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: latches an operand pair on start, pushes
// one bit pair per clock (LSB first) through a single full-adder cell and
// publishes sum, carry-out and signed overflow with a one-cycle done pulse.
module serial_adder_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_MSB = CNT_W'(WIDTH - 2);

    ctrlState_t       r_state;
    logic [WIDTH-1:0] r_aSr;
    logic [WIDTH-1:0] r_bSr;
    logic [WIDTH-2:0] r_sumSr;
    logic             r_carry;
    logic             r_cMsb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_cellSum;
    logic             w_cellCo;
    logic [WIDTH-1:0] w_sumShift;

    full_adder_cell u_cell (
        .a   (r_aSr[0]),
        .b   (r_bSr[0]),
        .cin (r_carry),
        .s   (w_cellSum),
        .co  (w_cellCo)
    );

    // The accumulator keeps only WIDTH-1 bits; the bit from the current
    // cycle completes the word, so the final result is this concatenation.
    always_comb begin
        w_sumShift = {w_cellSum, r_sumSr};
    end

    // Sequencer: load on accepted start, shift one bit per cycle while
    // running, and register the result on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_aSr   <= '0;
            r_bSr   <= '0;
            r_sumSr <= '0;
            r_carry <= 1'b0;
            r_cMsb  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_aSr   <= a;
                        r_bSr   <= b;
                        r_carry <= cin;
                        r_cMsb  <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_aSr   <= r_aSr >> 1;
                    r_bSr   <= r_bSr >> 1;
                    r_sumSr <= w_sumShift[WIDTH-1:1];
                    r_carry <= w_cellCo;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_PRE_MSB) begin
                        r_cMsb <= w_cellCo;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_sum   <= w_sumShift;
                        r_cout  <= w_cellCo;
                        r_ovf   <= r_cMsb ^ w_cellCo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial addition controller that time-multiplexes a single full-adder cell across an N-bit operand pair. The cell is built from two half adders and an OR gate. The block latches operands on a start request and feeds one bit pair per clock through the cell, LSB first. It accumulates sum bits in a shift register and reports sum, carry-out and signed overflow with a one-cycle done pulse. It is the sequencing layer above the combinational adder cells, for area-constrained arithmetic.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), width of internal bit counter (derived, not overridden)

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous reset, active-high
start  input   1      request new addition; sampled only when not busy
a      input   WIDTH  operand A, sampled on accepted start
b      input   WIDTH  operand B, sampled on accepted start
cin    input   1      carry-in, sampled on accepted start
busy   output  1      high while the operation is in RUN
done   output  1      single-cycle pulse: result valid
sum    output  WIDTH  result; held stable from done until next accepted start
cout   output  1      carry out of MSB; held like sum
ovf    output  1      signed overflow (carry into MSB XOR carry out of MSB); held like sum

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0. Operand shift regs, carry reg and counter are all 0.
- FSM states:
  - IDLE: start=1 -> load a_sr=a, b_sr=b, carry=cin, cnt=0, go to RUN.
  - RUN: busy=1. Each cycle: cell inputs (a_sr[0], b_sr[0], carry). sum_sr shifts right with the cell sum entering at MSB. a_sr and b_sr shift right. carry<=cell carry. cnt++. On the cycle cnt==WIDTH-2 the carry into the MSB is captured into c_msb. On the cycle cnt==WIDTH-1: sum<=final shifted value, cout<=cell carry, ovf<=c_msb^cell carry, go to DONE.
  - DONE: done=1, busy=0, one cycle. start=1 here is accepted (load as in IDLE, go to RUN); otherwise go to IDLE.
- Latency: start accepted at edge t -> busy high for cycles t+1..t+WIDTH; done high in cycle t+WIDTH+1. Throughput is one result per WIDTH+1 cycles with back-to-back start.
- start while in RUN: ignored, no side effects. Operand inputs are don't-care except on an accepted start.
- sum/cout/ovf update only at the RUN->DONE transition and never change mid-operation. The previous result stays visible during a new RUN.
- Reset asserted mid-RUN: abort next edge, all outputs cleared, no done pulse.
- Arithmetic: {cout,sum} == a + b + cin (unsigned, WIDTH+1 bits). ovf == (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).

Decomposition:
- Shared package serial_arith_pkg: FSM state enum (IDLE, RUN, DONE; 2-bit encoding) and the WIDTH default constant.
- One sub-module: full_adder_cell (a, b, cin -> s, co). Internally it uses two halfAdder instances and an or_gate, and is instantiated once in serial_adder_ctrl. All sequential logic stays in the top.

Test Plan:
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> done at cycle 9 after start; sum=0x00, cout=1, ovf=0; busy high exactly 8 cycles.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1, ovf=0. Back-to-back start in the DONE cycle with a=0x12, b=0x34, cin=0 -> next done 9 cycles later, sum=0x46, cout=0.
- start pulsed in RUN cycle 3 with different operands -> ignored; result matches the first operands and there is exactly one done pulse.
- rst asserted in RUN cycle 4 -> next cycle busy=0, sum=0, cout=0, ovf=0, no done. A later start computes correctly.
- WIDTH=3 exhaustive: all a, b, cin (128 cases) -> {cout,sum}==a+b+cin and ovf matches the signed rule, checked on every done.
